// File: rtl/tone_synth.sv
`default_nettype none
// =============================================================================
// Module   : tone_synth
// Purpose  : Per-key square-wave voices, popcount mixer and PWM speaker drive.
//            Define TONE_AUTOGAIN_EN to scale gain by the active voice count.
// Revision : 1.0 - initial release
// =============================================================================
module tone_synth #(
    parameter int NUM_VOICES = 13,
    parameter int CNT_W      = 32,
    parameter int PWM_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [CNT_W-1:0]      half_period [NUM_VOICES],
    output logic [NUM_VOICES-1:0] voice_wave,
    output logic [3:0]            active_count,
    output logic [PWM_W-1:0]      level,
    output logic                  pwm_sync,
    output logic                  spk_out
);

    localparam int               c_LEVEL_MAX = (2 ** PWM_W) - 1;
    localparam logic [PWM_W-1:0] c_ALL_ONES  = PWM_W'(c_LEVEL_MAX);

    // ---------------------------------------------------------------- voices
    logic [CNT_W-1:0]      cnt_q [NUM_VOICES];
    logic [CNT_W-1:0]      cnt_d [NUM_VOICES];
    logic [CNT_W-1:0]      hp_q  [NUM_VOICES];
    logic [NUM_VOICES-1:0] wave_q;
    logic [NUM_VOICES-1:0] wave_d;

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            cnt_d[i]  = cnt_q[i] + CNT_W'(1);
            wave_d[i] = wave_q[i];
            if (half_period[i] == '0) begin
                cnt_d[i]  = '0;
                wave_d[i] = 1'b0;
            end else if (half_period[i] != hp_q[i]) begin
                // Fresh press or pitch change restarts the phase high.
                cnt_d[i]  = '0;
                wave_d[i] = 1'b1;
            end else if (cnt_q[i] == half_period[i] - CNT_W'(1)) begin
                cnt_d[i]  = '0;
                wave_d[i] = ~wave_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                cnt_q[i] <= '0;
                hp_q[i]  <= '0;
            end
            wave_q <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                cnt_q[i] <= cnt_d[i];
                hp_q[i]  <= half_period[i];
            end
            wave_q <= wave_d;
        end
    end

    // ----------------------------------------------------------------- mixer
    logic [3:0]       sum;
    logic [3:0]       active_d;
    logic [3:0]       active_q;
    logic [PWM_W-1:0] gain;
    logic [PWM_W+3:0] prod;
    logic [PWM_W-1:0] level_d;
    logic [PWM_W-1:0] level_q;

    always_comb begin
        sum      = '0;
        active_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            sum      = sum + 4'(wave_q[i]);
            active_d = active_d + 4'(half_period[i] != '0);
        end
    end

`ifdef TONE_AUTOGAIN_EN
    always_comb begin
        gain = '0;
        for (int n = 1; n < 16; n++) begin
            if (active_q == 4'(n)) begin
                gain = PWM_W'(c_LEVEL_MAX / n);
            end
        end
    end
`else
    localparam int c_GAIN = c_LEVEL_MAX / NUM_VOICES;
    assign gain = PWM_W'(c_GAIN);
`endif

    always_comb begin
        prod    = (PWM_W+4)'(sum) * (PWM_W+4)'(gain);
        level_d = (prod > (PWM_W+4)'(c_LEVEL_MAX)) ? c_ALL_ONES : prod[PWM_W-1:0];
    end

    // ------------------------------------------------------------------- pwm
    logic [PWM_W-1:0] pwm_cnt_q;
    logic [PWM_W-1:0] pwm_cnt_d;
    logic [PWM_W-1:0] level_lat_q;
    logic [PWM_W-1:0] level_lat_d;
    logic             frame_end;
    logic             pwm_sync_q;
    logic             spk_q;

    // Level is only sampled at the frame boundary so a frame never mixes two levels.
    always_comb begin
        frame_end   = (pwm_cnt_q == c_ALL_ONES);
        pwm_cnt_d   = pwm_cnt_q + PWM_W'(1);
        level_lat_d = frame_end ? level_q : level_lat_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active_q    <= '0;
            level_q     <= '0;
            pwm_cnt_q   <= '0;
            level_lat_q <= '0;
            pwm_sync_q  <= 1'b0;
            spk_q       <= 1'b0;
        end else begin
            active_q    <= active_d;
            level_q     <= level_d;
            pwm_cnt_q   <= pwm_cnt_d;
            level_lat_q <= level_lat_d;
            pwm_sync_q  <= frame_end;
            spk_q       <= (pwm_cnt_d < level_lat_d);
        end
    end

    assign voice_wave   = wave_q;
    assign active_count = active_q;
    assign level        = level_q;
    assign pwm_sync     = pwm_sync_q;
    assign spk_out      = spk_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_synth.sv
`default_nettype none
// =============================================================================
// Module   : tb_tone_synth
// Purpose  : Directed vector table plus corner sequences for tone_synth.
// Revision : 1.0 - initial release
// =============================================================================
module tb_tone_synth;

    localparam int NV = 13;
`ifdef TONE_AUTOGAIN_EN
    localparam bit AG = 1'b1;
`else
    localparam bit AG = 1'b0;
`endif
    localparam int EXP_SINGLE = AG ? 255 : 19;
    localparam int EXP_CHORD  = 247;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   hp [NV];
    logic [NV-1:0] voice_wave;
    logic [3:0]    active_count;
    logic [7:0]    level;
    logic          pwm_sync;
    logic          spk_out;

    int total = 0;
    int bad   = 0;

    tone_synth dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .half_period  (hp),
        .voice_wave   (voice_wave),
        .active_count (active_count),
        .level        (level),
        .pwm_sync     (pwm_sync),
        .spk_out      (spk_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic clear_hp();
        for (int i = 0; i < NV; i++) hp[i] = '0;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        repeat (n) tick();
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] hp0;
        logic [31:0] hp1;
        logic [1:0]  wave;
        logic [3:0]  act;
        logic [7:0]  lvl;
        logic [7:0]  lvl_ag;
    } vec_t;

    vec_t tbl [30];

    initial begin
        int err_a, err_b, err_c, hi_a, hi_b, pulses;
        logic exp_w;

        // {hp0, hp1, wave{w1,w0}, active, level fixed-gain, level auto-gain}
        tbl[0]  = '{32'd4, 32'd0, 2'b01, 4'd1, 8'd0,  8'd0};
        tbl[1]  = '{32'd4, 32'd0, 2'b01, 4'd1, 8'd19, 8'd255};
        tbl[2]  = '{32'd4, 32'd0, 2'b01, 4'd1, 8'd19, 8'd255};
        tbl[3]  = '{32'd4, 32'd0, 2'b01, 4'd1, 8'd19, 8'd255};
        tbl[4]  = '{32'd4, 32'd0, 2'b00, 4'd1, 8'd19, 8'd255};
        tbl[5]  = '{32'd4, 32'd0, 2'b00, 4'd1, 8'd0,  8'd0};
        tbl[6]  = '{32'd4, 32'd0, 2'b00, 4'd1, 8'd0,  8'd0};
        tbl[7]  = '{32'd4, 32'd0, 2'b00, 4'd1, 8'd0,  8'd0};
        tbl[8]  = '{32'd4, 32'd0, 2'b01, 4'd1, 8'd0,  8'd0};
        tbl[9]  = '{32'd4, 32'd0, 2'b01, 4'd1, 8'd19, 8'd255};
        tbl[10] = '{32'd4, 32'd0, 2'b01, 4'd1, 8'd19, 8'd255};
        tbl[11] = '{32'd4, 32'd0, 2'b01, 4'd1, 8'd19, 8'd255};
        tbl[12] = '{32'd2, 32'd0, 2'b01, 4'd1, 8'd19, 8'd255};
        tbl[13] = '{32'd2, 32'd0, 2'b01, 4'd1, 8'd19, 8'd255};
        tbl[14] = '{32'd2, 32'd0, 2'b00, 4'd1, 8'd19, 8'd255};
        tbl[15] = '{32'd2, 32'd0, 2'b00, 4'd1, 8'd0,  8'd0};
        tbl[16] = '{32'd2, 32'd0, 2'b01, 4'd1, 8'd0,  8'd0};
        tbl[17] = '{32'd2, 32'd0, 2'b01, 4'd1, 8'd19, 8'd255};
        tbl[18] = '{32'd0, 32'd0, 2'b00, 4'd0, 8'd19, 8'd255};
        tbl[19] = '{32'd0, 32'd0, 2'b00, 4'd0, 8'd0,  8'd0};
        tbl[20] = '{32'd0, 32'd1, 2'b10, 4'd1, 8'd0,  8'd0};
        tbl[21] = '{32'd0, 32'd1, 2'b00, 4'd1, 8'd19, 8'd255};
        tbl[22] = '{32'd0, 32'd1, 2'b10, 4'd1, 8'd0,  8'd0};
        tbl[23] = '{32'd0, 32'd1, 2'b00, 4'd1, 8'd19, 8'd255};
        tbl[24] = '{32'd1, 32'd1, 2'b11, 4'd2, 8'd0,  8'd0};
        tbl[25] = '{32'd1, 32'd1, 2'b00, 4'd2, 8'd38, 8'd254};
        tbl[26] = '{32'd1, 32'd1, 2'b11, 4'd2, 8'd0,  8'd0};
        tbl[27] = '{32'd1, 32'd1, 2'b00, 4'd2, 8'd38, 8'd254};
        tbl[28] = '{32'd0, 32'd1, 2'b10, 4'd1, 8'd0,  8'd0};
        tbl[29] = '{32'd3, 32'd0, 2'b01, 4'd1, 8'd19, 8'd255};

        // Reset holds every output low even with a key pressed.
        clear_hp();
        hp[0]   = 32'd4;
        reset_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("reset%0d outputs", c),
                32'({voice_wave, active_count, level, pwm_sync, spk_out}), 32'd0);
        end
        reset_n = 1'b1;

        for (int r = 0; r < 30; r++) begin
            hp[0] = tbl[r].hp0;
            hp[1] = tbl[r].hp1;
            tick();
            chk($sformatf("vec%0d wave", r), 32'(voice_wave), 32'(tbl[r].wave));
            chk($sformatf("vec%0d active", r), 32'(active_count), 32'(tbl[r].act));
            chk($sformatf("vec%0d level", r), 32'(level), AG ? 32'(tbl[r].lvl_ag) : 32'(tbl[r].lvl));
        end

        // Release and retrigger on voice 5.
        clear_hp();
        do_reset(3);
        err_a = 0;
        for (int e = 1; e <= 62; e++) begin
            hp[5] = (e <= 36) ? 32'd10 : (e < 50) ? 32'd0 : 32'd6;
            tick();
            if (e <= 36)     exp_w = (((e - 1) / 10) % 2) == 0;
            else if (e < 50) exp_w = 1'b0;
            else             exp_w = (((e - 50) / 6) % 2) == 0;
            if (voice_wave !== (NV'(exp_w) << 5)) err_a++;
            if (e == 37) chk("retrig release", 32'(voice_wave), 32'd0);
            if (e == 50) chk("retrig press", 32'(voice_wave), 32'h20);
            if (e == 56) chk("retrig first toggle", 32'(voice_wave), 32'd0);
        end
        chk("retrig wave errors", 32'(err_a), 32'd0);

        // Single long voice, reset mid-frame: frame timing and PWM duty.
        clear_hp();
        hp[3] = 32'd95556;
        do_reset(3);
        err_a = 0; err_b = 0; hi_a = 0; pulses = 0;
        for (int e = 1; e <= 1280; e++) begin
            tick();
            if (pwm_sync !== ((e % 256) == 0)) err_a++;
            if (pwm_sync === 1'b1) pulses++;
            if (spk_out !== ((e >= 256) && ((e % 256) < EXP_SINGLE))) err_b++;
            if (e >= 256 && e < 512 && spk_out === 1'b1) hi_a++;
            if (e == 300) begin
                chk("single wave", 32'(voice_wave), 32'h8);
                chk("single active", 32'(active_count), 32'd1);
                chk("single level", 32'(level), 32'(EXP_SINGLE));
            end
        end
        chk("pwm_sync placement errors", 32'(err_a), 32'd0);
        chk("pwm_sync pulse count", 32'(pulses), 32'd5);
        chk("single spk shape errors", 32'(err_b), 32'd0);
        chk("single spk high per frame", 32'(hi_a), 32'(EXP_SINGLE));

        // Full chord at half_period=1, pressed one cycle after reset release.
        clear_hp();
        do_reset(3);
        err_a = 0; err_b = 0; err_c = 0; hi_a = 0; hi_b = 0;
        for (int e = 1; e <= 800; e++) begin
            if (e == 2) for (int i = 0; i < NV; i++) hp[i] = 32'd1;
            tick();
            if (voice_wave !== ((e >= 2 && (e % 2) == 0) ? {NV{1'b1}} : {NV{1'b0}})) err_a++;
            if (level !== ((e >= 3 && (e % 2) == 1) ? 8'(EXP_CHORD) : 8'd0)) err_b++;
            if (spk_out !== ((e >= 256) && ((e % 256) < EXP_CHORD))) err_c++;
            if (e >= 256 && e < 512 && spk_out === 1'b1) hi_a++;
            if (e >= 512 && e < 768 && spk_out === 1'b1) hi_b++;
            if (e == 10) chk("chord active", 32'(active_count), 32'd13);
            if (e == 5)  chk("chord level peak", 32'(level), 32'(EXP_CHORD));
        end
        chk("chord wave errors", 32'(err_a), 32'd0);
        chk("chord level errors", 32'(err_b), 32'd0);
        chk("chord spk shape errors", 32'(err_c), 32'd0);
        chk("chord frame1 high", 32'(hi_a), 32'(EXP_CHORD));
        chk("chord frame2 high", 32'(hi_b), 32'(EXP_CHORD));

        // Maximum half-period never toggles within the window.
        clear_hp();
        hp[0] = 32'hFFFF_FFFF;
        do_reset(2);
        err_a = 0;
        for (int e = 1; e <= 3000; e++) begin
            tick();
            if (voice_wave !== NV'(1)) err_a++;
        end
        chk("max half-period toggles", 32'(err_a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
